// File: rtl/i2s_sample_feeder_pkg.sv
// Shared audio definitions for the synth output path (sample feeder and I2S controller).
package i2s_sample_feeder_pkg;

  localparam int SAMPLE_W = 16;
  localparam int UCNT_W   = 8;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_t;

  function automatic stereo_t make_pair(input logic signed [SAMPLE_W-1:0] l,
                                        input logic signed [SAMPLE_W-1:0] r);
    stereo_t p;
    p.left  = l;
    p.right = r;
    return p;
  endfunction

endpackage

// File: rtl/i2s_sample_feeder_if.sv
// Bundle between the synth voice path, the sample feeder and the I2S controller.
interface i2s_sample_feeder_if
  import i2s_sample_feeder_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_left;
  logic signed [WIDTH-1:0] in_right;
  logic                    frame_clk;
  logic signed [WIDTH-1:0] sample_left;
  logic signed [WIDTH-1:0] sample_right;
  logic [AW:0]             level;
  logic                    underrun;
  logic [UCNT_W-1:0]       underrun_count;

  modport slave (
    input  in_valid, in_left, in_right, frame_clk,
    output in_ready, sample_left, sample_right, level, underrun, underrun_count
  );

  modport master (
    output in_valid, in_left, in_right, frame_clk,
    input  in_ready, sample_left, sample_right, level, underrun, underrun_count
  );

endinterface

// File: rtl/i2s_sample_feeder_sync_fifo.sv
// Generic single-clock FIFO; push when full and pop when empty are ignored.
module i2s_sample_feeder_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_level = r_level;

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_feeder.sv
// Buffers stereo pairs from the synth path and hands one pair per I2S frame to the controller.
module i2s_sample_feeder
  import i2s_sample_feeder_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  i2s_sample_feeder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
    return (v == '1) ? v : v + UCNT_W'(1);
  endfunction

  logic                    w_full;
  logic                    w_empty;
  logic [LW-1:0]           w_level;
  logic [2*WIDTH-1:0]      w_head;
  logic                    w_in_ready;
  logic                    w_push;
  logic                    w_frame_fall;
  logic                    w_pop;

  logic                    r_frame_clk_q;
  logic signed [WIDTH-1:0] r_left;
  logic signed [WIDTH-1:0] r_right;
  logic                    r_underrun;
  logic [UCNT_W-1:0]       r_ucnt;

  // Ready depends only on registered occupancy, so a full FIFO refuses even on a pop cycle.
  assign w_in_ready   = ~reset & ~w_full;
  assign w_push       = bus.in_valid & w_in_ready;
  assign w_frame_fall = r_frame_clk_q & ~bus.frame_clk;
  assign w_pop        = w_frame_fall & ~w_empty;

  i2s_sample_feeder_sync_fifo #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({bus.in_left, bus.in_right}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Frame boundary: load the head pair (or silence) one cycle after the word-select fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_clk_q <= 1'b0;
      r_left        <= '0;
      r_right       <= '0;
      r_underrun    <= 1'b0;
      r_ucnt        <= '0;
    end else begin
      r_frame_clk_q <= bus.frame_clk;
      r_underrun    <= 1'b0;
      if (w_frame_fall) begin
        if (!w_empty) begin
          {r_left, r_right} <= w_head;
        end else begin
          r_left     <= '0;
          r_right    <= '0;
          r_underrun <= 1'b1;
          r_ucnt     <= sat_inc(r_ucnt);
        end
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.sample_left    = r_left;
  assign bus.sample_right   = r_right;
  assign bus.level          = w_level;
  assign bus.underrun       = r_underrun;
  assign bus.underrun_count = r_ucnt;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Scoreboard bench for i2s_sample_feeder: a queue model tracks accepted pairs and frame pops.
module tb_i2s_sample_feeder;
  import i2s_sample_feeder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  i2s_sample_feeder_if #(.WIDTH(16), .DEPTH(8)) bus ();

  i2s_sample_feeder #(.WIDTH(16), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state
  stereo_t    sb_q[$];
  stereo_t    m_out   = '0;
  logic       m_ur    = 1'b0;
  int         m_ucnt  = 0;
  logic       m_fq    = 1'b0;

  always @(negedge clk) begin
    logic fall;
    logic acc;
    check("mon_left",   16'(bus.sample_left),    16'(m_out.left));
    check("mon_right",  16'(bus.sample_right),   16'(m_out.right));
    check("mon_level",  16'(bus.level),          16'(sb_q.size()));
    check("mon_ur",     16'(bus.underrun),       16'(m_ur));
    check("mon_ucnt",   16'(bus.underrun_count), 16'(m_ucnt));
    check("mon_ready",  16'(bus.in_ready),       16'(!reset && sb_q.size() != 8));
    if (reset) begin
      sb_q.delete();
      m_out  = '0;
      m_ur   = 1'b0;
      m_ucnt = 0;
      m_fq   = 1'b0;
    end else begin
      fall = m_fq && !bus.frame_clk;
      acc  = bus.in_valid && (sb_q.size() != 8);
      m_ur = 1'b0;
      if (fall) begin
        if (sb_q.size() > 0) begin
          m_out = sb_q.pop_front();
        end else begin
          m_out = '0;
          m_ur  = 1'b1;
          if (m_ucnt < 255) m_ucnt++;
        end
      end
      if (acc) sb_q.push_back(make_pair(bus.in_left, bus.in_right));
      m_fq = bus.frame_clk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame();
    bus.frame_clk = 1'b1;
    tick();
    bus.frame_clk = 1'b0;
    tick();
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    bus.in_valid = 1'b1;
    bus.in_left  = l;
    bus.in_right = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.frame_clk = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;
    bus.frame_clk = 1'b0;
    tick();
    tick();
    check("rst_left",  16'(bus.sample_left), 16'h0000);
    check("rst_level", 16'(bus.level), 16'd0);
    check("rst_ready", 16'(bus.in_ready), 16'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 16'(bus.in_ready), 16'd1);

    // Idle with frames: underrun per frame, counter saturates
    do_frame();
    check("idle_ur_pulse", 16'(bus.underrun), 16'd1);
    check("idle_ucnt1", 16'(bus.underrun_count), 16'd1);
    tick();
    check("idle_ur_clear", 16'(bus.underrun), 16'd0);
    repeat (299) do_frame();
    check("idle_ucnt_sat", 16'(bus.underrun_count), 16'd255);
    check("idle_left", 16'(bus.sample_left), 16'h0000);

    // Two pairs before the first frame
    do_reset();
    push(16'd17, 16'd17);
    push(16'd100, 16'hFF9C);
    check("two_level2", 16'(bus.level), 16'd2);
    do_frame();
    check("two_left1",  16'(bus.sample_left), 16'd17);
    check("two_right1", 16'(bus.sample_right), 16'd17);
    check("two_level1", 16'(bus.level), 16'd1);
    do_frame();
    check("two_left2",  16'(bus.sample_left), 16'd100);
    check("two_right2", 16'(bus.sample_right), 16'hFF9C);
    check("two_level0", 16'(bus.level), 16'd0);
    check("two_no_ur",  16'(bus.underrun_count), 16'd0);

    // Fill to full, reject ninth
    for (int i = 0; i < 8; i++) push(16'($urandom), 16'($urandom));
    check("full_level", 16'(bus.level), 16'd8);
    check("full_ready", 16'(bus.in_ready), 16'd0);
    push(16'h7FFF, 16'h8000);
    check("ninth_rejected", 16'(bus.level), 16'd8);
    do_frame();
    check("after_pop_level", 16'(bus.level), 16'd7);
    check("after_pop_ready", 16'(bus.in_ready), 16'd1);

    // Full with in_valid held through the pop cycle
    push(16'h0101, 16'h0202);
    check("refill_level", 16'(bus.level), 16'd8);
    bus.in_valid = 1'b1;
    bus.in_left  = 16'h0A0A;
    bus.in_right = 16'hF5F5;
    do_frame();
    check("pop_cycle_level", 16'(bus.level), 16'd7);
    tick();
    bus.in_valid = 1'b0;
    check("held_accept_level", 16'(bus.level), 16'd8);
    repeat (8) do_frame();
    check("drained_left",  16'(bus.sample_left), 16'h0A0A);
    check("drained_right", 16'(bus.sample_right), 16'hF5F5);
    check("drained_level", 16'(bus.level), 16'd0);

    // Push coinciding with an empty-FIFO pop
    do_reset();
    bus.frame_clk = 1'b1;
    tick();
    bus.frame_clk = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_left   = 16'h0ABC;
    bus.in_right  = 16'hFFFB;
    tick();
    bus.in_valid = 1'b0;
    check("coin_ur",    16'(bus.underrun), 16'd1);
    check("coin_left",  16'(bus.sample_left), 16'h0000);
    check("coin_level", 16'(bus.level), 16'd1);
    do_frame();
    check("coin_next_left",  16'(bus.sample_left), 16'h0ABC);
    check("coin_next_right", 16'(bus.sample_right), 16'hFFFB);

    // Reset mid-operation
    push(16'h1234, 16'h1234);
    do_frame();
    for (int i = 0; i < 5; i++) push(16'(i + 1), 16'(-(i + 1)));
    check("pre_rst_left",  16'(bus.sample_left), 16'h1234);
    check("pre_rst_level", 16'(bus.level), 16'd5);
    check("pre_rst_ucnt",  16'(bus.underrun_count), 16'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_left",  16'(bus.sample_left), 16'h0000);
    check("mid_rst_right", 16'(bus.sample_right), 16'h0000);
    check("mid_rst_level", 16'(bus.level), 16'd0);
    check("mid_rst_ucnt",  16'(bus.underrun_count), 16'd0);
    check("mid_rst_ready", 16'(bus.in_ready), 16'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 16'(bus.in_ready), 16'd1);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_sample_feeder.md
Name: i2s_sample_feeder

Overview:
Stereo sample buffer directly upstream of i2s_controller. It accepts left/right sample pairs from the synth voice path via a valid/ready handshake and stores them in a small FIFO. It drives the controller's sample_left/sample_right inputs with exactly one new pair per I2S frame, paced by the controller's frame_clk. It absorbs burstiness in the synth path and flags underruns.

Parameters:
WIDTH, 16, bits per channel sample (matches i2s_controller sample width)
DEPTH, 8, FIFO depth in stereo pairs; power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived; not overridden)

Ports:
clk  input  1  system clock; same clock as i2s_controller
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream has a stereo pair on in_left/in_right
in_ready  output  1  feeder can accept a pair this cycle
in_left  input  WIDTH  left sample, two's complement
in_right  input  WIDTH  right sample, two's complement
frame_clk  input  1  word-select from i2s_controller (low = left half); same clock domain, no synchroniser
sample_left  output  WIDTH  registered left sample to i2s_controller
sample_right  output  WIDTH  registered right sample to i2s_controller
level  output  AW+1  current FIFO occupancy, 0..DEPTH
underrun  output  1  one-cycle pulse when a frame pop finds the FIFO empty
underrun_count  output  8  saturating count of underrun events

Behaviour:
- Single clock. All state updates on posedge clk. Reset is synchronous, active-high, and takes priority over every other event.
- Reset values:
  - sample_left = 0, sample_right = 0
  - level = 0, read/write pointers = 0
  - underrun = 0, underrun_count = 0
  - frame_clk_q = 0
  - in_ready = 0 while reset is high
- Reset mid-operation discards all buffered pairs. No handshake completes in a reset cycle.
- in_ready = !reset && (level != DEPTH). It is combinational from registered level and does not depend on a same-cycle pop. A push is never accepted when full, even if a pop occurs that cycle.
- Push: in_valid && in_ready writes {in_left, in_right} at wptr; wptr increments and wraps modulo DEPTH.
- Frame event: frame_fall = frame_clk_q && !frame_clk, where frame_clk_q is frame_clk registered once. This marks the start of the left half, the point at which i2s_controller captures both samples.
- Pop on frame_fall:
  - If level != 0: sample_left/sample_right load the head pair on the next posedge (1-cycle latency from the frame_fall cycle); rptr increments and wraps.
  - If level == 0: sample_left/sample_right load 0 (silence); underrun pulses high for exactly that one cycle; underrun_count increments and saturates at 255.
  - A push in the same cycle as an empty-FIFO pop is stored normally. It is not bypassed to the outputs.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- sample_left/sample_right are held constant between frame_fall events, so they are stable for the whole frame.
- The first pair pushed after reset appears on the outputs after the first frame_fall that follows it. The controller transmits that pair in the frame after the one in which it was loaded.
- level updates the cycle after a push/pop and always equals (writes − reads) mod 2^(AW+1).

Decomposition:
- Shared audio package holds:
  - SAMPLE_W = 16
  - a stereo pair typedef {left, right}, used by both the feeder and i2s_controller
- Natural sub-module: sync_fifo.
  - Generic synchronous FIFO, width 2*WIDTH, depth DEPTH, with push/pop/full/empty/level.
  - The feeder wraps it with the frame-edge detect, output registers and underrun logic.

Test Plan:
- Reset then idle, frame_clk toggling -> outputs 0; underrun pulses once per frame_fall; underrun_count increments by 1 per frame and saturates at 255 after 300 frames.
- Push (17,17) then (100,-100) before the first frame_fall -> after the 1st frame_fall outputs = 17/17; after the 2nd = 100/0xFF9C; level goes 2→1→0; no underrun.
- Push 8 pairs without frames -> level = 8, in_ready = 0; a 9th in_valid is not accepted. After one frame_fall, level = 7 and in_ready = 1 the next cycle.
- Full FIFO with in_valid held high through a frame_fall cycle -> that cycle's push is not accepted; the following cycle accepts; level returns to 8.
- Empty FIFO, push coincides with a frame_fall cycle -> outputs 0 and underrun = 1 that frame; the pushed pair appears at the next frame_fall.
- Assert reset with 5 pairs buffered and outputs = 0x1234 -> next cycle outputs = 0, level = 0, underrun_count = 0, in_ready = 0 during reset and 1 after.
